// File: rtl/rx_slicer_if.sv
// Channel-to-slicer bus: faded level and enable in, recovered bit and link status out.
interface rx_slicer_if #(
  parameter int LEVEL_W = 10,
  parameter int RUN_W   = 8
);
  logic               enable;
  logic [LEVEL_W-1:0] level_in;
  logic               bit_out;
  logic               edge_pulse;
  logic [RUN_W-1:0]   run_len;
  logic               los;

  modport master (
    output enable, level_in,
    input  bit_out, edge_pulse, run_len, los
  );

  modport slave (
    input  enable, level_in,
    output bit_out, edge_pulse, run_len, los
  );
endinterface

// File: rtl/rx_slicer.sv
// Hysteresis + debounce bit slicer for the channel's faded level, with transition
// reporting, saturating run length and loss-of-signal detection.
module rx_slicer #(
  parameter int LEVEL_W    = 10,
  parameter int THR_HI     = 160,
  parameter int THR_LO     = 96,
  parameter int DEBOUNCE   = 3,
  parameter int RUN_W      = 8,
  parameter int LOS_CYCLES = 200
) (
  input  logic        faster_clk,
  input  logic        rst_n,
  rx_slicer_if.slave  bus
);
  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_e;

  localparam logic [LEVEL_W-1:0] HI      = LEVEL_W'(THR_HI);
  localparam logic [LEVEL_W-1:0] LO      = LEVEL_W'(THR_LO);
  localparam logic [3:0]         DEB     = 4'(DEBOUNCE);
  localparam logic [RUN_W-1:0]   LOS_N   = RUN_W'(LOS_CYCLES);
  localparam logic [RUN_W-1:0]   RUN_MAX = {RUN_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d, cnt_inc;
  logic             bit_q, bit_d;
  logic             edge_q, edge_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             los_q, los_d;
  logic             qual_hi, qual_lo, flip;

  assign qual_hi = bus.level_in >= HI;
  assign qual_lo = bus.level_in <= LO;
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    case (state_q)
      S_LOW:
        if (qual_hi) begin
          if (DEB == 4'd1) begin
            state_d = S_HIGH;
            flip    = 1'b1;
          end else begin
            state_d = S_RISE;
            cnt_d   = 4'd1;
          end
        end
      S_RISE:
        if (qual_hi) begin
          if (cnt_inc == DEB) begin
            state_d = S_HIGH;
            cnt_d   = 4'd0;
            flip    = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // dead-band samples abort the debounce as well
          state_d = S_LOW;
          cnt_d   = 4'd0;
        end
      S_HIGH:
        if (qual_lo) begin
          if (DEB == 4'd1) begin
            state_d = S_LOW;
            flip    = 1'b1;
          end else begin
            state_d = S_FALL;
            cnt_d   = 4'd1;
          end
        end
      default:
        if (qual_lo) begin
          if (cnt_inc == DEB) begin
            state_d = S_LOW;
            cnt_d   = 4'd0;
            flip    = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = S_HIGH;
          cnt_d   = 4'd0;
        end
    endcase

    run_len_d = flip ? '0 : ((run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_W'(1));
    // run_len only climbs between flips, so ">=" covers both set and hold
    los_d     = !flip && (run_len_d >= LOS_N);
    edge_d    = flip;
    bit_d     = (state_d == S_HIGH) || (state_d == S_FALL);

    if (!bus.enable) begin
      state_d   = S_LOW;
      cnt_d     = 4'd0;
      bit_d     = 1'b0;
      edge_d    = 1'b0;
      run_len_d = '0;
      los_d     = 1'b0;
    end
  end

  always_ff @(posedge faster_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOW;
      cnt_q     <= 4'd0;
      bit_q     <= 1'b0;
      edge_q    <= 1'b0;
      run_len_q <= '0;
      los_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      edge_q    <= edge_d;
      run_len_q <= run_len_d;
      los_q     <= los_d;
    end
  end

  assign bus.bit_out    = bit_q;
  assign bus.edge_pulse = edge_q;
  assign bus.run_len    = run_len_q;
  assign bus.los        = los_q;
endmodule

// File: tb/tb_rx_slicer.sv
// Directed bench for rx_slicer: vector table for slicing/hysteresis, hand sequences
// for ramp, LOS saturation, enable drop and async reset mid-debounce.
module tb_rx_slicer;
  logic faster_clk = 1'b0;
  logic rst_n      = 1'b0;
  int   n_vec      = 0;
  int   n_err      = 0;

  always #5 faster_clk = ~faster_clk;

  rx_slicer_if #(.LEVEL_W(10), .RUN_W(8)) bus ();

  rx_slicer dut (
    .faster_clk (faster_clk),
    .rst_n      (rst_n),
    .bus        (bus.slave)
  );

  typedef struct {
    logic       en;
    logic [9:0] lvl;
    logic       bo;
    logic       ep;
    logic [7:0] rl;
    logic       los;
  } vec_t;

  vec_t vecs [25];

  task automatic step();
    @(posedge faster_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic bo, input logic ep,
                     input logic [7:0] rl, input logic los);
    n_vec++;
    if (bus.bit_out !== bo || bus.edge_pulse !== ep || bus.run_len !== rl || bus.los !== los) begin
      n_err++;
      $display("FAIL %s: got bit=%b edge=%b run=%0d los=%b, want bit=%b edge=%b run=%0d los=%b",
               name, bus.bit_out, bus.edge_pulse, bus.run_len, bus.los, bo, ep, rl, los);
    end
  endtask

  initial begin
    vecs = '{
      // enable drop from bit=1/run=37: cleared with no pulse
      '{1'b0, 10'd200, 1'b0, 1'b0, 8'd0, 1'b0},
      '{1'b1, 10'd200, 1'b0, 1'b0, 8'd1, 1'b0},
      '{1'b1, 10'd200, 1'b0, 1'b0, 8'd2, 1'b0},
      '{1'b1, 10'd200, 1'b1, 1'b1, 8'd0, 1'b0},
      // dead band hold, then falling glitch rejected, then clean fall
      '{1'b1, 10'd120, 1'b1, 1'b0, 8'd1, 1'b0},
      '{1'b1, 10'd90,  1'b1, 1'b0, 8'd2, 1'b0},
      '{1'b1, 10'd120, 1'b1, 1'b0, 8'd3, 1'b0},
      '{1'b1, 10'd90,  1'b1, 1'b0, 8'd4, 1'b0},
      '{1'b1, 10'd90,  1'b1, 1'b0, 8'd5, 1'b0},
      '{1'b1, 10'd90,  1'b0, 1'b1, 8'd0, 1'b0},
      // rising glitch: 170,170,120,170 then two more 170
      '{1'b1, 10'd170, 1'b0, 1'b0, 8'd1, 1'b0},
      '{1'b1, 10'd170, 1'b0, 1'b0, 8'd2, 1'b0},
      '{1'b1, 10'd120, 1'b0, 1'b0, 8'd3, 1'b0},
      '{1'b1, 10'd170, 1'b0, 1'b0, 8'd4, 1'b0},
      '{1'b1, 10'd170, 1'b0, 1'b0, 8'd5, 1'b0},
      '{1'b1, 10'd170, 1'b1, 1'b1, 8'd0, 1'b0},
      '{1'b1, 10'd170, 1'b1, 1'b0, 8'd1, 1'b0},
      // exact threshold boundaries: 97 dead, 96 qualifies, 159 dead, 160 qualifies
      '{1'b1, 10'd97,  1'b1, 1'b0, 8'd2, 1'b0},
      '{1'b1, 10'd96,  1'b1, 1'b0, 8'd3, 1'b0},
      '{1'b1, 10'd96,  1'b1, 1'b0, 8'd4, 1'b0},
      '{1'b1, 10'd96,  1'b0, 1'b1, 8'd0, 1'b0},
      '{1'b1, 10'd159, 1'b0, 1'b0, 8'd1, 1'b0},
      '{1'b1, 10'd160, 1'b0, 1'b0, 8'd2, 1'b0},
      '{1'b1, 10'd160, 1'b0, 1'b0, 8'd3, 1'b0},
      '{1'b1, 10'd160, 1'b1, 1'b1, 8'd0, 1'b0}
    };

    bus.enable   = 1'b1;
    bus.level_in = '0;
    #12;
    chk("reset", 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge faster_clk);
    rst_n = 1'b1;

    // ramp: 160,161,162 qualify, bit rises at the 162 edge
    for (int v = 0; v <= 162; v++) begin
      bus.level_in = 10'(v);
      step();
      if (v == 159) chk("ramp_159", 1'b0, 1'b0, 8'd160, 1'b0);
      if (v == 161) chk("ramp_161", 1'b0, 1'b0, 8'd162, 1'b0);
      if (v == 162) chk("ramp_rise", 1'b1, 1'b1, 8'd0, 1'b0);
    end
    bus.level_in = 10'd200;
    step();
    chk("ramp_after", 1'b1, 1'b0, 8'd1, 1'b0);
    repeat (36) step();
    chk("run_37", 1'b1, 1'b0, 8'd37, 1'b0);

    for (int i = 0; i < 25; i++) begin
      bus.enable   = vecs[i].en;
      bus.level_in = vecs[i].lvl;
      step();
      chk($sformatf("vec%0d", i), vecs[i].bo, vecs[i].ep, vecs[i].rl, vecs[i].los);
    end

    // hysteresis hold in dead band: LOS at 200, saturation at 255
    bus.enable   = 1'b1;
    bus.level_in = 10'd120;
    for (int i = 1; i <= 500; i++) begin
      step();
      chk($sformatf("hold%0d", i), 1'b1, 1'b0, 8'((i > 255) ? 255 : i), (i >= 200));
    end

    // fall clears LOS on the same edge as the pulse
    bus.level_in = 10'd90;
    step();
    chk("fall1", 1'b1, 1'b0, 8'd255, 1'b1);
    step();
    chk("fall2", 1'b1, 1'b0, 8'd255, 1'b1);
    step();
    chk("fall3", 1'b0, 1'b1, 8'd0, 1'b0);

    // async reset while in S_RISE with cnt=2
    bus.level_in = 10'd200;
    step();
    step();
    chk("pre_rst", 1'b0, 1'b0, 8'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 1'b0, 1'b0, 8'd0, 1'b0);
    #1 rst_n = 1'b1;
    step();
    step();
    chk("post_rst2", 1'b0, 1'b0, 8'd2, 1'b0);
    step();
    chk("post_rst3", 1'b1, 1'b1, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rx_slicer.md
# rx_slicer

Receiver decision stage that sits directly downstream of the `channel` model. It samples the channel's 10-bit faded level on every `faster_clk` edge and slices it into a recovered bit using hysteresis thresholds and a consecutive-sample debounce. It also reports each bit transition, the run length since the last transition, and loss-of-signal when no transition occurs for a programmable interval.

## Interface

Parameters:
- `LEVEL_W`, 10: width of `level_in`.
- `THR_HI`, 160: rising threshold. A sample qualifies high when `level_in >= THR_HI`.
- `THR_LO`, 96: falling threshold. A sample qualifies low when `level_in <= THR_LO`. Requires `THR_LO < THR_HI`.
- `DEBOUNCE`, 3: number of consecutive qualifying samples needed to flip `bit_out`. Range 1..15.
- `RUN_W`, 8: width of `run_len`.
- `LOS_CYCLES`, 200: number of transition-free cycles that asserts `los`. Range 1..2^RUN_W-1.

Ports:
- `faster_clk`, in, 1: sample clock, 10 ns period. Reset is `rst_n`, asynchronous, active-low; the clock is `faster_clk`.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: slicer enable, synchronous.
- `level_in`, in, `LEVEL_W`: unsigned faded level from the channel.
- `bit_out`, out, 1: recovered bit, registered.
- `edge_pulse`, out, 1: one-cycle pulse in the cycle where `bit_out` changes.
- `run_len`, out, `RUN_W`: cycles since the last `bit_out` change. Saturating.
- `los`, out, 1: loss-of-signal flag, registered.

## Operation

- **Reset values.** `bit_out`=0, `edge_pulse`=0, `run_len`=0, `los`=0. FSM state is S_LOW and the debounce counter `cnt` is 0.
- **FSM states.** S_LOW, S_RISE, S_HIGH, S_FALL. `bit_out` is 0 in S_LOW and S_RISE, and 1 in S_HIGH and S_FALL.
- **S_LOW.**
  - Sample qualifies high and `DEBOUNCE`=1: go to S_HIGH.
  - Sample qualifies high and `DEBOUNCE`>1: go to S_RISE with `cnt`=1.
  - Otherwise: stay.
- **S_RISE.**
  - Sample qualifies high: `cnt`+1. When the incremented value equals `DEBOUNCE`, go to S_HIGH and clear `cnt`.
  - Any non-qualifying sample, including samples in the dead band: return to S_LOW, `cnt`=0, no pulse.
- **S_HIGH and S_FALL.** Mirror S_LOW and S_RISE, using the "qualifies low" test.
- **Dead band.** `THR_LO < level_in < THR_HI` never qualifies in either direction. S_LOW and S_HIGH hold.
- **`edge_pulse`.** Equals 1 for exactly the cycle after the edge that flips `bit_out`. It is never asserted on two consecutive cycles unless `DEBOUNCE`=1.
- **`run_len`.**
  - Loads 0 on the edge that flips `bit_out`.
  - Otherwise increments by 1 per cycle.
  - Saturates at 2^RUN_W-1; it never wraps.
- **`los`.**
  - Set on the edge where `run_len` becomes equal to `LOS_CYCLES`.
  - Stays set while `run_len` is at or above `LOS_CYCLES`.
  - Cleared on the edge that flips `bit_out`.
- **`enable`=0.** Synchronously forces S_LOW, `cnt`=0, `bit_out`=0, `edge_pulse`=0, `run_len`=0, `los`=0. No edge pulse is generated by this forced clear. On re-enable, normal slicing resumes from S_LOW on the next edge.
- **Reset mid-debounce.** Aborts immediately to the reset values.
- **Arithmetic.** All comparisons are unsigned at `LEVEL_W` bits. `cnt` is 4 bits.

## Timing

- `level_in` is sampled on every rising edge of `faster_clk`. There is no input register.
- Latency: if samples k, k+1, ..., k+DEBOUNCE-1 qualify, `bit_out` and `edge_pulse` are updated at edge k+DEBOUNCE-1. They are visible in the following cycle.
- `edge_pulse` width is exactly 1 cycle.
- `los` asserts `LOS_CYCLES` cycles after the last edge pulse, and deasserts at the same edge that raises `edge_pulse`.
- With the channel ramping 1 LSB per cycle from 0, the first high decision occurs `THR_HI`+`DEBOUNCE`-1 cycles after the ramp starts.

## Test plan

1. **Reset then ramp up.** Hold `rst_n`=0, then release. Ramp `level_in` from 0 upward, +1 per cycle.
   - Expect `bit_out` to rise at the edge where `level_in`=162 (160, 161, 162 qualify).
   - Expect one `edge_pulse` and `run_len`=0 in the following cycle.
2. **Glitch rejection.** From S_LOW, drive 170, 170, 120, 170.
   - Expect no transition, because the 120 sample resets the debounce.
   - Two further samples of 170 then set `bit_out`=1.
3. **Hysteresis hold.** From S_HIGH, drive 120 for 500 cycles.
   - Expect `bit_out` to stay 1.
   - Expect `los`=1 at the edge where `run_len`=200, and `run_len` to saturate at 255.
4. **Fall and LOS clear.** Continuing from scenario 3, drive 90 for 3 cycles.
   - Expect `bit_out`=0, one `edge_pulse`, `los`=0, `run_len`=0 on the same edge.
5. **Enable drop.** With `bit_out`=1 and `run_len`=37, drive `enable`=0 for 1 cycle.
   - Expect `bit_out`=0, `run_len`=0, `los`=0, and no `edge_pulse`.
   - After re-enable, 3 samples of 200 raise `bit_out` again.
6. **Async reset mid-debounce.** In S_RISE with `cnt`=2, pulse `rst_n` low between clock edges.
   - Expect all outputs at reset values immediately.
   - After release, 3 fresh qualifying samples are needed to raise `bit_out`.
